exu_muldiv_sched: RTL

Parametrised multiply/divide scheduler, the next generation of the EXU mul/div control path. It accepts mul/div requests from dispatch and drives a pipelined multiplier (several ops in flight) and an iterative divider (one op in flight). Per-unit result FIFOs buffer returned results, and a configurable arbiter writes them back. Sits between dispatch and the writeback/commit stage and replaces single-entry result holding with buffered, flushable tracking.

---
 rtl/exu_muldiv_sched.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/exu_muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module   : exu_muldiv_sched
// Brief    : Mul/div scheduler. Issues dispatch requests to a pipelined
//            multiplier and an iterative divider, tracks destination tags,
//            buffers returned results in per-unit FIFOs and arbitrates them
//            onto the writeback port. Flush kills buffered results and
//            discards results still owed by the units.
// Options  : MULDIV_WB_BYPASS_EN - a unit result arriving while both result
//            FIFOs are empty drives writeback in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module exu_muldiv_sched #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 5,
  parameter int CID_W           = 4,
  parameter int MUL_OUTSTANDING = 4,
  parameter int RES_DEPTH       = 4,
  parameter int ARB_RR          = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_muldiv_i,
  input  logic [7:0]        muldiv_op_i,
  input  logic [DATA_W-1:0] reg1_rdata_i,
  input  logic [DATA_W-1:0] reg2_rdata_i,
  input  logic [ADDR_W-1:0] reg_waddr_i,
  input  logic [CID_W-1:0]  commit_id_i,
  input  logic              flush_i,
  output logic              muldiv_stall_flag_o,
  output logic              mul_start_o,
  output logic [3:0]        mul_op_o,
  output logic [DATA_W-1:0] mul_multiplicand_o,
  output logic [DATA_W-1:0] mul_multiplier_o,
  input  logic              mul_busy_i,
  input  logic              mul_valid_i,
  input  logic [DATA_W-1:0] mul_result_i,
  output logic              div_start_o,
  output logic [3:0]        div_op_o,
  output logic [DATA_W-1:0] div_dividend_o,
  output logic [DATA_W-1:0] div_divisor_o,
  input  logic              div_busy_i,
  input  logic              div_valid_i,
  input  logic [DATA_W-1:0] div_result_i,
  output logic              reg_we_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic [ADDR_W-1:0] reg_waddr_o,
  output logic [CID_W-1:0]  commit_id_o,
  input  logic              wb_ready,
  output logic              idle_o
);

  localparam int c_MPTR_W = (MUL_OUTSTANDING > 1) ? $clog2(MUL_OUTSTANDING) : 1;
  localparam int c_MCNT_W = $clog2(MUL_OUTSTANDING) + 1;
  localparam int c_RPTR_W = $clog2(RES_DEPTH);
  localparam int c_RCNT_W = c_RPTR_W + 1;
  localparam int c_SUM_W  = ((c_MCNT_W > c_RCNT_W) ? c_MCNT_W : c_RCNT_W) + 1;
  localparam int c_TAG_W  = ADDR_W + CID_W;
  localparam int c_ENT_W  = DATA_W + c_TAG_W;

  logic                w_onehot, w_is_mul, w_is_div;
  logic                w_mul_accept, w_div_accept;
  logic [c_SUM_W-1:0]  w_mul_outst, w_mul_credit;

  logic [c_TAG_W-1:0]  r_tag_mem [MUL_OUTSTANDING];
  logic [c_MPTR_W-1:0] r_tag_wptr, r_tag_rptr;
  logic [c_MCNT_W-1:0] r_mul_cnt, r_mul_drop;
  logic                w_tag_pop, w_mul_drop_hit, w_mul_ret;

  logic [c_TAG_W-1:0]  r_div_tag;
  logic                r_div_busy, r_div_drop, w_div_ret;

  logic [c_ENT_W-1:0]  w_push_data [2];
  logic [c_ENT_W-1:0]  w_head      [2];
  logic [c_RCNT_W-1:0] w_res_cnt   [2];
  logic [1:0]          w_push, w_pop, w_ne;

  logic                w_sel_mul, w_bypass, w_hs, r_rr_ptr;
  logic [c_ENT_W-1:0]  w_wb_ent;

  function automatic logic [c_MPTR_W-1:0] f_tag_inc(input logic [c_MPTR_W-1:0] p);
    return (p == c_MPTR_W'(MUL_OUTSTANDING - 1)) ? '0 : p + c_MPTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode and acceptance. Malformed one-hot codes are ignored.
  // Dropped-but-unreturned mul ops still occupy the multiplier, so they count
  // against the outstanding limit; the FIFO credit only covers live ops.
  // ---------------------------------------------------------------------------
  assign w_onehot     = $onehot(muldiv_op_i);
  assign w_is_mul     = req_muldiv_i & w_onehot & (|muldiv_op_i[3:0]);
  assign w_is_div     = req_muldiv_i & w_onehot & (|muldiv_op_i[7:4]);
  assign w_mul_outst  = c_SUM_W'(r_mul_cnt) + c_SUM_W'(r_mul_drop);
  assign w_mul_credit = c_SUM_W'(r_mul_cnt) + c_SUM_W'(w_res_cnt[0]);

  assign w_mul_accept = w_is_mul & ~mul_busy_i & ~flush_i
                      & (w_mul_outst  < c_SUM_W'(MUL_OUTSTANDING))
                      & (w_mul_credit < c_SUM_W'(RES_DEPTH));
  assign w_div_accept = w_is_div & ~div_busy_i & ~flush_i & ~r_div_busy & ~r_div_drop
                      & (w_res_cnt[1] < c_RCNT_W'(RES_DEPTH));

  assign muldiv_stall_flag_o = (w_is_mul | w_is_div) & ~(w_mul_accept | w_div_accept);
  assign mul_start_o         = w_mul_accept;
  assign mul_op_o            = w_mul_accept ? muldiv_op_i[3:0] : 4'h0;
  assign mul_multiplicand_o  = reg1_rdata_i;
  assign mul_multiplier_o    = reg2_rdata_i;
  assign div_start_o         = w_div_accept;
  assign div_op_o            = w_div_accept ? muldiv_op_i[7:4] : 4'h0;
  assign div_dividend_o      = reg1_rdata_i;
  assign div_divisor_o       = reg2_rdata_i;

  // ---------------------------------------------------------------------------
  // Multiplier tag tracking. Drops are older than every live tag, so returning
  // results retire pending drops first and only then pop tags.
  // ---------------------------------------------------------------------------
  assign w_mul_drop_hit = mul_valid_i & (r_mul_drop != '0);
  assign w_tag_pop      = mul_valid_i & (r_mul_drop == '0);
  assign w_mul_ret      = w_tag_pop & ~flush_i;

  // Tag storage, written at issue
  always_ff @(posedge clk) begin
    if (w_mul_accept) r_tag_mem[r_tag_wptr] <= {reg_waddr_i, commit_id_i};
  end

  // Tag pointers, live count and drop count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
      r_mul_cnt  <= '0;
      r_mul_drop <= '0;
    end else if (flush_i) begin
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
      r_mul_cnt  <= '0;
      r_mul_drop <= c_MCNT_W'(w_mul_outst - c_SUM_W'(mul_valid_i && (w_mul_outst != '0)));
    end else begin
      if (w_mul_accept) r_tag_wptr <= f_tag_inc(r_tag_wptr);
      if (w_tag_pop)    r_tag_rptr <= f_tag_inc(r_tag_rptr);
      r_mul_cnt <= r_mul_cnt + c_MCNT_W'(w_mul_accept) - c_MCNT_W'(w_tag_pop);
      if (w_mul_drop_hit) r_mul_drop <= r_mul_drop - c_MCNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Divider tag: one op at a time, either live or waiting to be discarded.
  // ---------------------------------------------------------------------------
  assign w_div_ret = div_valid_i & ~r_div_drop & ~flush_i;

  // Divider in-flight, drop flag and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_busy <= 1'b0;
      r_div_drop <= 1'b0;
      r_div_tag  <= '0;
    end else if (flush_i) begin
      r_div_busy <= 1'b0;
      r_div_drop <= (r_div_busy | r_div_drop) & ~div_valid_i;
    end else begin
      if (div_valid_i) begin
        if (r_div_drop) r_div_drop <= 1'b0;
        else            r_div_busy <= 1'b0;
      end
      if (w_div_accept) begin
        r_div_busy <= 1'b1;
        r_div_tag  <= {reg_waddr_i, commit_id_i};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFOs: index 0 = multiplier, 1 = divider.
  // ---------------------------------------------------------------------------
  assign w_push_data[0] = {mul_result_i, r_tag_mem[r_tag_rptr]};
  assign w_push_data[1] = {div_result_i, r_div_tag};

  for (genvar u = 0; u < 2; u++) begin : g_res
    logic [c_ENT_W-1:0]  r_mem [RES_DEPTH];
    logic [c_RPTR_W-1:0] r_wptr, r_rptr;
    logic [c_RCNT_W-1:0] r_cnt;

    // Entry storage
    always_ff @(posedge clk) begin
      if (w_push[u]) r_mem[r_wptr] <= w_push_data[u];
    end

    // Pointers and occupancy; flush empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else if (flush_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[u]) r_wptr <= r_wptr + c_RPTR_W'(1);
        if (w_pop[u])  r_rptr <= r_rptr + c_RPTR_W'(1);
        r_cnt <= r_cnt + c_RCNT_W'(w_push[u]) - c_RCNT_W'(w_pop[u]);
      end
    end

    assign w_head[u]    = r_mem[r_rptr];
    assign w_res_cnt[u] = r_cnt;
    assign w_ne[u]      = (r_cnt != '0);
  end

  // ---------------------------------------------------------------------------
  // Writeback arbitration (and optional same-cycle bypass when both FIFOs are
  // empty). r_rr_ptr = 0 favours mul, 1 favours div.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_mul = 1'b1;
    w_bypass  = 1'b0;
    if (w_ne[0] && w_ne[1]) begin
      w_sel_mul = (ARB_RR == 0) ? 1'b1 : ~r_rr_ptr;
    end else if (w_ne[0]) begin
      w_sel_mul = 1'b1;
    end else if (w_ne[1]) begin
      w_sel_mul = 1'b0;
    end
`ifdef MULDIV_WB_BYPASS_EN
    else if (w_mul_ret && w_div_ret) begin
      w_bypass  = 1'b1;
      w_sel_mul = (ARB_RR == 0) ? 1'b1 : ~r_rr_ptr;
    end else if (w_mul_ret) begin
      w_bypass  = 1'b1;
      w_sel_mul = 1'b1;
    end else if (w_div_ret) begin
      w_bypass  = 1'b1;
      w_sel_mul = 1'b0;
    end
`endif
  end

  assign reg_we_o = (|w_ne) | w_bypass;
  assign w_hs     = reg_we_o & wb_ready;
  assign w_wb_ent = ~reg_we_o ? '0 :
                    w_bypass  ? (w_sel_mul ? w_push_data[0] : w_push_data[1]) :
                                (w_sel_mul ? w_head[0]      : w_head[1]);
  assign {reg_wdata_o, reg_waddr_o, commit_id_o} = w_wb_ent;

  assign w_pop[0]  = w_hs & ~w_bypass &  w_sel_mul;
  assign w_pop[1]  = w_hs & ~w_bypass & ~w_sel_mul;
  assign w_push[0] = w_mul_ret & ~(w_bypass &  w_sel_mul & wb_ready);
  assign w_push[1] = w_div_ret & ~(w_bypass & ~w_sel_mul & wb_ready);

  // Round-robin pointer moves to the other unit after each handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rr_ptr <= 1'b0;
    else if (w_hs) r_rr_ptr <= w_sel_mul;
  end

  assign idle_o = (r_mul_cnt == '0) & (r_mul_drop == '0) & ~r_div_busy & ~r_div_drop & ~(|w_ne);

`ifndef SYNTHESIS
  // A unit result with nothing issued or pending drop means tags are out of step
  a_mul_orphan: assert property (@(posedge clk) disable iff (!rst_n)
    !(mul_valid_i && (r_mul_cnt == '0) && (r_mul_drop == '0)));
  a_div_orphan: assert property (@(posedge clk) disable iff (!rst_n)
    !(div_valid_i && !r_div_busy && !r_div_drop));
`endif

endmodule
`default_nettype wire
